// File: rtl/load_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : load_pkg                                                         |
// | Purpose  : Shared types and constants for the AXI4-Stream load demux:      |
// |            state encoding, command codes, default memory depths and the    |
// |            address widths derived from them.                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package load_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_P = 2'd1,
    LOAD_I = 2'd2,
    DONE   = 2'd3
  } load_state_t;

  localparam logic [1:0] CMD_LOAD_PARAM = 2'd1;
  localparam logic [1:0] CMD_LOAD_IMG   = 2'd2;
  localparam logic [1:0] CMD_RUN        = 2'd3;

  localparam int unsigned DEF_W_DEPTH   = 12672;
  localparam int unsigned DEF_B_DEPTH   = 129;
  localparam int unsigned DEF_IMG_DEPTH = 576;

  localparam int unsigned W_ADDR_W   = $clog2(DEF_W_DEPTH);
  localparam int unsigned B_ADDR_W   = $clog2(DEF_B_DEPTH);
  localparam int unsigned IMG_ADDR_W = $clog2(DEF_IMG_DEPTH);

  // The single beat counter serves both load types, so it is sized for the
  // deeper of the two.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_addr_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : load_addr_cnt                                                    |
// | Purpose  : Clearable, enabled beat counter with a terminal-count flag.     |
// | Ports    : clk, rst      - clock, synchronous active-high reset            |
// |            clr           - clear count to 0 (priority over en)            |
// |            en            - advance count by one                           |
// |            last_idx      - index at which tc is raised                    |
// |            count         - current beat index                             |
// |            tc            - count == last_idx                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module load_addr_cnt #(
  parameter int unsigned WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last_idx,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == last_idx);

endmodule
`default_nettype wire

// File: rtl/axis_load_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axis_load_demux                                                  |
// | Purpose  : Accepts AXI4-Stream beats and routes them to the weight/bias    |
// |            memories (parameter load) or the image buffer (image load),    |
// |            selected by the control module's command. Reports completion   |
// |            pulses and a sticky length-mismatch flag.                      |
// | Ports    : clk, rst                 - clock, synchronous active-high reset |
// |            start, cmd, busy         - command handshake                   |
// |            s_axis_*                 - stream slave                        |
// |            w_wr_*, b_wr_*, img_wr_* - registered memory write ports       |
// |            param_done, img_done     - one-cycle completion pulses         |
// |            len_err                  - sticky length mismatch              |
// |            checksum                 - sum of accepted beats               |
// | Options  : LOAD_CHECKSUM_EN - when defined, checksum accumulates the      |
// |            accepted tdata of the current load; otherwise it is tied to 0. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module axis_load_demux
  import load_pkg::*;
#(
  parameter int unsigned W_DEPTH   = DEF_W_DEPTH,
  parameter int unsigned B_DEPTH   = DEF_B_DEPTH,
  parameter int unsigned IMG_DEPTH = DEF_IMG_DEPTH,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            cmd,
  output logic                  busy,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  w_wr_en,
  output logic [W_ADDR_W-1:0]   w_wr_addr,
  output logic [23:0]           w_wr_data,
  output logic                  b_wr_en,
  output logic [B_ADDR_W-1:0]   b_wr_addr,
  output logic [7:0]            b_wr_data,
  output logic                  img_wr_en,
  output logic [IMG_ADDR_W-1:0] img_wr_addr,
  output logic [DATA_W-1:0]     img_wr_data,
  output logic                  param_done,
  output logic                  img_done,
  output logic                  len_err,
  output logic [DATA_W-1:0]     checksum
);

  localparam int unsigned CNT_W = cnt_width(W_DEPTH, IMG_DEPTH);

  load_state_t      r_state;
  load_state_t      w_state_nxt;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_last_idx;
  logic             w_tc;
  logic             w_loading;
  logic             w_accept;
  logic             w_start_p;
  logic             w_start_i;
  logic             w_clr;
  logic             w_term;
  logic             w_acc_p;
  logic             w_acc_i;

  assign w_loading     = (r_state == LOAD_P) || (r_state == LOAD_I);
  assign s_axis_tready = w_loading;
  assign busy          = w_loading;
  assign w_accept      = s_axis_tvalid && w_loading;
  assign w_acc_p       = w_accept && (r_state == LOAD_P);
  assign w_acc_i       = w_accept && (r_state == LOAD_I);

  // Commands are only honoured from IDLE; start while busy falls through.
  assign w_start_p = (r_state == IDLE) && start && (cmd == CMD_LOAD_PARAM);
  assign w_start_i = (r_state == IDLE) && start && (cmd == CMD_LOAD_IMG);
  assign w_clr     = w_start_p || w_start_i;

  assign w_last_idx = (r_state == LOAD_I) ? CNT_W'(IMG_DEPTH - 1) : CNT_W'(W_DEPTH - 1);

  // Whichever comes first - tlast or the final index - ends the load.
  assign w_term = w_accept && (s_axis_tlast || w_tc);

  load_addr_cnt #(
    .WIDTH (CNT_W)
  ) u_addr_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr),
    .en       (w_accept),
    .last_idx (w_last_idx),
    .count    (w_cnt),
    .tc       (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_p) begin
          w_state_nxt = LOAD_P;
        end else if (w_start_i) begin
          w_state_nxt = LOAD_I;
        end
      end
      LOAD_P, LOAD_I: begin
        if (w_term) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Write ports are registered one cycle behind acceptance; the done pulse is
  // registered alongside so that it lines up with the final write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_wr_en     <= 1'b0;
      w_wr_addr   <= '0;
      w_wr_data   <= '0;
      b_wr_en     <= 1'b0;
      b_wr_addr   <= '0;
      b_wr_data   <= '0;
      img_wr_en   <= 1'b0;
      img_wr_addr <= '0;
      img_wr_data <= '0;
      param_done  <= 1'b0;
      img_done    <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      w_wr_en    <= w_acc_p;
      b_wr_en    <= w_acc_p && (w_cnt < CNT_W'(B_DEPTH));
      img_wr_en  <= w_acc_i;
      param_done <= w_term && (r_state == LOAD_P);
      img_done   <= w_term && (r_state == LOAD_I);

      if (w_acc_p) begin
        w_wr_addr <= W_ADDR_W'(w_cnt);
        w_wr_data <= s_axis_tdata[23:0];
      end
      if (w_acc_p && (w_cnt < CNT_W'(B_DEPTH))) begin
        b_wr_addr <= B_ADDR_W'(w_cnt);
        b_wr_data <= s_axis_tdata[31:24];
      end
      if (w_acc_i) begin
        img_wr_addr <= IMG_ADDR_W'(w_cnt);
        img_wr_data <= s_axis_tdata;
      end

      // Mismatch when exactly one of tlast / final-index is present.
      if (w_term && (s_axis_tlast != w_tc)) begin
        len_err <= 1'b1;
      end
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + s_axis_tdata;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_load_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axis_load_demux                                               |
// | Purpose  : Self-checking bench for axis_load_demux. Beats are driven on    |
// |            the falling edge, writes are collected on the falling edge and |
// |            compared with the expected write list derived from the beat    |
// |            array and the load termination rule.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_axis_load_demux;

  localparam int TB_W_DEPTH   = 12672;
  localparam int TB_B_DEPTH   = 129;
  localparam int TB_IMG_DEPTH = 576;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  cmd;
  logic        busy;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        w_wr_en;
  logic [13:0] w_wr_addr;
  logic [23:0] w_wr_data;
  logic        b_wr_en;
  logic [7:0]  b_wr_addr;
  logic [7:0]  b_wr_data;
  logic        img_wr_en;
  logic [9:0]  img_wr_addr;
  logic [31:0] img_wr_data;
  logic        param_done;
  logic        img_done;
  logic        len_err;
  logic [31:0] checksum;

  always #5 clk = ~clk;

  axis_load_demux dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cmd           (cmd),
    .busy          (busy),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .w_wr_en       (w_wr_en),
    .w_wr_addr     (w_wr_addr),
    .w_wr_data     (w_wr_data),
    .b_wr_en       (b_wr_en),
    .b_wr_addr     (b_wr_addr),
    .b_wr_data     (b_wr_data),
    .img_wr_en     (img_wr_en),
    .img_wr_addr   (img_wr_addr),
    .img_wr_data   (img_wr_data),
    .param_done    (param_done),
    .img_done      (img_done),
    .len_err       (len_err),
    .checksum      (checksum)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [37:0] w_q[$];
  logic [15:0] b_q[$];
  logic [41:0] i_q[$];
  int          pd_cnt;
  int          id_cnt;
  int          misalign;
  int          stray;
  bit          acc_edge;
  bit [31:0]   beats[$];
  bit          exp_len_err;

  // Handshake as seen by the DUT at the rising edge.
  always @(posedge clk) acc_edge = s_axis_tvalid && s_axis_tready;

  always @(negedge clk) begin
    if (w_wr_en)   w_q.push_back({w_wr_addr, w_wr_data});
    if (b_wr_en)   b_q.push_back({b_wr_addr, b_wr_data});
    if (img_wr_en) i_q.push_back({img_wr_addr, img_wr_data});
    if ((w_wr_en || b_wr_en || img_wr_en) && !acc_edge) stray++;
    if (param_done) begin pd_cnt++; if (!w_wr_en)   misalign++; end
    if (img_done)   begin id_cnt++; if (!img_wr_en) misalign++; end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    w_q.delete(); b_q.delete(); i_q.delete();
    pd_cnt = 0; id_cnt = 0; misalign = 0; stray = 0;
  endtask

  task automatic fill_random(input int n, input bit [31:0] first);
    beats.delete();
    beats.push_back(first);
    for (int i = 1; i < n; i++) beats.push_back($urandom);
  endtask

  // Group j of 48 beats carries bytes {4j+3, 4j+2, 4j+1, 4j}.
  task automatic fill_image(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) begin
      int j;
      j = i / 48;
      beats.push_back({8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)});
    end
  endtask

  task automatic drive_load(input logic [1:0] c, input int nbeats, input int tlast_at,
                            input bit throttle, input int rst_at, input int inj_at,
                            output int accepted);
    accepted = 0;
    @(negedge clk); #1; start = 1'b1; cmd = c;
    @(negedge clk); #1; start = 1'b0; cmd = 2'd0;
    for (int i = 0; i < nbeats; i++) begin
      if (throttle) begin
        while ($urandom_range(0, 2) == 0) begin
          s_axis_tvalid = 1'b0; s_axis_tdata = $urandom; s_axis_tlast = 1'b0;
          @(negedge clk); #1;
        end
      end
      if (i == rst_at) begin
        rst = 1'b1; s_axis_tvalid = 1'b0;
        break;
      end
      if (!s_axis_tready) begin
        // Offer the surplus beat for a while; it must never be taken.
        s_axis_tvalid = 1'b1; s_axis_tdata = beats[i]; s_axis_tlast = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        break;
      end
      if (i == inj_at) begin start = 1'b1; cmd = 2'd2; end
      s_axis_tvalid = 1'b1; s_axis_tdata = beats[i]; s_axis_tlast = (i == tlast_at);
      accepted++;
      @(negedge clk); #1; start = 1'b0; cmd = 2'd0;
    end
    if (!rst) s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    chk({tag, "_idle"}, 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, 64'({busy, s_axis_tready, w_wr_en, b_wr_en, img_wr_en,
                             param_done, img_done, len_err}), 64'(0));
    chk({tag, "_addr"}, 64'({w_wr_addr, b_wr_addr, img_wr_addr}), 64'(0));
    chk({tag, "_data"}, 64'({w_wr_data, b_wr_data, img_wr_data}), 64'(0));
    chk({tag, "_csum"}, 64'(checksum), 64'(0));
  endtask

  // Expected writes: every beat up to the terminating one, where the load
  // ends at the first tlast or at the final index of the memory.
  task automatic check_load(input string tag, input bit is_img, input int tlast_at, input int accepted);
    int        depth;
    int        t;
    int        n;
    int        nb;
    int        nbad;
    bit [31:0] sum;
    depth = is_img ? TB_IMG_DEPTH : TB_W_DEPTH;
    t     = depth - 1;
    if (tlast_at >= 0 && tlast_at < t) t = tlast_at;
    n     = t + 1;
    nb    = (n < TB_B_DEPTH) ? n : TB_B_DEPTH;
    if (tlast_at != depth - 1) exp_len_err = 1'b1;
    sum   = 32'd0;
    for (int i = 0; i < n; i++) sum += beats[i];

    chk({tag, "_accepted"}, 64'(accepted), 64'(n));
    nbad = 0;
    if (is_img) begin
      chk({tag, "_img_cnt"}, 64'(i_q.size()), 64'(n));
      chk({tag, "_w_cnt"},   64'(w_q.size()), 64'(0));
      for (int i = 0; i < i_q.size() && i < n; i++)
        if (i_q[i] !== {10'(i), beats[i]}) nbad++;
      chk({tag, "_img_content_bad"}, 64'(nbad), 64'(0));
    end else begin
      chk({tag, "_w_cnt"},   64'(w_q.size()), 64'(n));
      chk({tag, "_b_cnt"},   64'(b_q.size()), 64'(nb));
      chk({tag, "_img_cnt"}, 64'(i_q.size()), 64'(0));
      for (int i = 0; i < w_q.size() && i < n; i++)
        if (w_q[i] !== {14'(i), beats[i][23:0]}) nbad++;
      for (int i = 0; i < b_q.size() && i < nb; i++)
        if (b_q[i] !== {8'(i), beats[i][31:24]}) nbad++;
      chk({tag, "_wb_content_bad"}, 64'(nbad), 64'(0));
    end
    chk({tag, "_param_done"}, 64'(pd_cnt), 64'(is_img ? 0 : 1));
    chk({tag, "_img_done"},   64'(id_cnt), 64'(is_img ? 1 : 0));
    chk({tag, "_done_align"}, 64'(misalign), 64'(0));
    chk({tag, "_stray_wr"},   64'(stray), 64'(0));
    chk({tag, "_len_err"},    64'(len_err), 64'(exp_len_err));
    chk({tag, "_tready"},     64'(s_axis_tready), 64'(0));
`ifdef LOAD_CHECKSUM_EN
    chk({tag, "_checksum"},   64'(checksum), 64'(sum));
`else
    chk({tag, "_checksum"},   64'(checksum), 64'(0));
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          acc;
    logic [15:0] b0;
    logic [37:0] w0;
    logic [41:0] im;

    rst = 1'b1; start = 1'b0; cmd = 2'd0;
    s_axis_tvalid = 1'b0; s_axis_tdata = 32'd0; s_axis_tlast = 1'b0;
    exp_len_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    #1; rst = 1'b0;
    clear_mon();

    // Nominal parameter load.
    fill_random(TB_W_DEPTH, 32'h05030201);
    drive_load(2'd1, TB_W_DEPTH, TB_W_DEPTH - 1, 1'b0, -1, -1, acc);
    wait_idle("param_nom");
    check_load("param_nom", 1'b0, TB_W_DEPTH - 1, acc);
    b0 = (b_q.size() > 0) ? b_q[0] : 16'hxxxx;
    w0 = (w_q.size() > 0) ? w_q[0] : 38'hx;
    chk("param_nom_b0", 64'(b0), 64'({8'h00, 8'h05}));
    chk("param_nom_w0", 64'(w0), 64'({14'd0, 24'h030201}));
    clear_mon();

    // Nominal image load.
    fill_image(TB_IMG_DEPTH);
    drive_load(2'd2, TB_IMG_DEPTH, TB_IMG_DEPTH - 1, 1'b0, -1, -1, acc);
    wait_idle("img_nom");
    check_load("img_nom", 1'b1, TB_IMG_DEPTH - 1, acc);
    im = (i_q.size() > 48) ? i_q[48] : 42'hx;
    chk("img_nom_a48", 64'(im), 64'({10'd48, 32'h07060504}));
    im = (i_q.size() > 575) ? i_q[575] : 42'hx;
    chk("img_nom_a575", 64'(im), 64'({10'd575, 32'h2f2e2d2c}));
    clear_mon();

    // Reserved command while idle is ignored.
    @(negedge clk); #1; start = 1'b1; cmd = 2'd3;
    @(negedge clk); #1; start = 1'b0; cmd = 2'd0;
    @(negedge clk);
    chk("cmd3_busy", 64'(busy), 64'(0));
    chk("cmd3_tready", 64'(s_axis_tready), 64'(0));

    // Early tlast on beat 100, with an image command issued while busy.
    fill_random(200, $urandom);
    drive_load(2'd1, 200, 100, 1'b0, -1, 50, acc);
    wait_idle("param_early");
    check_load("param_early", 1'b0, 100, acc);
    clear_mon();

    // Throttled image load right after the error; write list matches nominal.
    fill_image(TB_IMG_DEPTH);
    drive_load(2'd2, TB_IMG_DEPTH, TB_IMG_DEPTH - 1, 1'b1, -1, -1, acc);
    wait_idle("img_thr");
    check_load("img_thr", 1'b1, TB_IMG_DEPTH - 1, acc);
    clear_mon();

    // Reset at beat 300 of a parameter load.
    fill_random(400, $urandom);
    drive_load(2'd1, 400, -1, 1'b0, 300, -1, acc);
    @(negedge clk);
    chk_all_zero("mid_rst");
    chk("mid_rst_accepted", 64'(acc), 64'(300));
    #1; rst = 1'b0;
    exp_len_err = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();

    // Overrun: 580 image beats without tlast.
    fill_image(580);
    drive_load(2'd2, 580, -1, 1'b0, -1, -1, acc);
    wait_idle("img_ovr");
    check_load("img_ovr", 1'b1, -1, acc);
    clear_mon();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
